fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter dataWidth, default 8, the width of one data beat.
REQ-002 The block SHALL have parameter numReq, default 4, the number of requesters (range 2..8).
REQ-003 The block SHALL have parameter maxBurst, default 4, the maximum beats per grant tenure (range 1..16).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-high (1 = reset, 0 = run).
REQ-006 The block SHALL have port req  input  numReq  per-requester write request; bit i is held high while requester i has a beat ready.
REQ-007 The block SHALL have port req_data  input  numReq*dataWidth  beat data; slice i is bits [i*dataWidth +: dataWidth].
REQ-008 The block SHALL have port fifo_full  input  1  the FIFO full flag.
REQ-009 The block SHALL have port fifo_almostFull  input  1  the FIFO almostFull flag.
REQ-010 The block SHALL have port grant  output  numReq  one-hot beat-accept strobe; grant[i]=1 means requester i's beat is written this cycle.
REQ-011 The block SHALL have port fifo_wr_en  output  1  the FIFO write enable.
REQ-012 The block SHALL have port fifo_data_in  output  dataWidth  the FIFO write data.
REQ-013 The block SHALL have port owner  output  $clog2(numReq)  index of the current tenure holder; 0 when idle.
REQ-014 The block SHALL have port busy  output  1  high while in state GRANT.

Function
REQ-015 The block SHALL implement a state machine with states IDLE and GRANT, plus registers owner, beat_cnt (0..maxBurst) and rr_ptr (next-priority index).
REQ-016 In IDLE with req!=0, the block SHALL select the first set req bit searching from rr_ptr upward with wrap, load owner, clear beat_cnt, and enter GRANT on the next edge (one-cycle arbitration latency, no beat written in IDLE).
REQ-017 In GRANT, a beat SHALL be accepted in any cycle where req[owner]=1 and fifo_full=0: grant[owner]=1, fifo_wr_en=1, fifo_data_in=req_data slice owner, beat_cnt increments.
REQ-018 grant, fifo_wr_en and fifo_data_in SHALL be combinational from registered state and current inputs; fifo_data_in SHALL be 0 whenever fifo_wr_en=0.
REQ-019 fifo_wr_en SHALL never be 1 while fifo_full=1; a full FIFO stalls the tenure without counting beats or releasing.
REQ-020 The tenure SHALL end at the edge after any of: req[owner]=0; an accepted beat brings beat_cnt to maxBurst; an accepted beat occurs while fifo_almostFull=1.
REQ-021 On tenure end, rr_ptr SHALL become (owner+1) mod numReq, and the next owner SHALL be chosen by the REQ-016 search from the new rr_ptr over the current req; if one is found the block SHALL stay in GRANT with the new owner and beat_cnt=0 (no bubble), else go to IDLE.
REQ-022 A requester hitting maxBurst and still requesting SHALL be re-granted only if no other requester is pending (it is searched last).
REQ-023 At most one grant bit SHALL be high in any cycle.

Reset
REQ-024 While rst_n=1 at an edge, state SHALL become IDLE, owner=0, beat_cnt=0, rr_ptr=0.
REQ-025 While rst_n=1, grant, fifo_wr_en, fifo_data_in and busy SHALL be forced to 0 in the same cycle; reset mid-tenure aborts it with no further beats.

Verification
REQ-026 Single requester: req=0001 held, data 10,11,12,...; fifo not full -> busy one cycle after req, beats 10..13 written on consecutive cycles, release, re-grant to 0 with no bubble, stream continues.
REQ-027 Round robin: req=1111 held, maxBurst=4 -> owners 0,1,2,3,0 each for exactly 4 grant cycles, no idle cycles between tenures.
REQ-028 Full stall: owner 2 mid-burst, fifo_full=1 for 3 cycles -> fifo_wr_en=0 and grant=0 for those 3 cycles, beat_cnt unchanged, burst resumes on the cycle fifo_full returns to 0.
REQ-029 almostFull: req=0011, fifo_almostFull=1 -> each tenure writes exactly 1 beat, owner alternates 0,1,0,1.
REQ-030 Early drop: owner 1 drops req after 2 beats while req[3]=1 -> owner 3 granted the next cycle, rr_ptr=2 after that handover.
REQ-031 Reset mid-burst: rst_n=1 during a GRANT cycle -> all outputs 0 that cycle, IDLE/owner 0/rr_ptr 0 after the edge, first grant after release goes to the lowest set req bit.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// FifoWrArbiter (fifo_wr_arbiter)
//
// Purpose:
//    Round-robin write arbiter. It merges several requesters into the write
//    port of a single FIFO. Each requester that wins arbitration holds a
//    grant tenure of up to maxBurst beats. The tenure ends early if the
//    requester drops its request, or if a beat is written while the FIFO
//    reports almostFull. A full FIFO stalls the tenure without ending it.
//    Handover to the next pending requester happens without an idle cycle.
//
// Ports:
//    clk             : single clock, all state changes on the rising edge
//    rst_n           : synchronous reset, active-high (1 = reset)
//    req             : per-requester beat-ready flags
//    req_data        : packed beat data; slice i is [i*dataWidth +: dataWidth]
//    fifo_full       : FIFO full flag, blocks writes
//    fifo_almostFull : FIFO almostFull flag, ends a tenure after one write
//    grant           : one-hot beat-accept strobe
//    fifo_wr_en      : FIFO write enable
//    fifo_data_in    : FIFO write data, zero when not writing
//    owner           : index of the current tenure holder, 0 when idle
//    busy            : high while a tenure is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int dataWidth = 8,
   parameter int numReq    = 4,
   parameter int maxBurst  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [numReq-1:0]             req,
   input  logic [numReq*dataWidth-1:0]   req_data,
   input  logic                          fifo_full,
   input  logic                          fifo_almostFull,
   output logic [numReq-1:0]             grant,
   output logic                          fifo_wr_en,
   output logic [dataWidth-1:0]          fifo_data_in,
   output logic [$clog2(numReq)-1:0]     owner,
   output logic                          busy
);

   localparam int OW = $clog2(numReq);
   localparam int CW = $clog2(maxBurst + 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   beatCnt_q, beatCnt_d;
   logic [OW-1:0]   rrPtr_q, rrPtr_d;

   logic            accept;
   logic            tenureEnd;
   logic [OW:0]     pick;
   logic [OW-1:0]   nextPtr;

   // Returns {found, index} of the first set request at or above ptr,
   // wrapping around. The loop runs downward so that the smallest offset
   // from ptr is the last assignment and therefore wins.
   function automatic logic [OW:0] pickNext(input logic [numReq-1:0] r,
                                            input logic [OW-1:0]     ptr);
      logic [OW-1:0] idx;
      pickNext = '0;
      for (int k = numReq - 1; k >= 0; k--) begin
         idx = OW'((int'(ptr) + k) % numReq);
         if (r[idx]) begin
            pickNext = {1'b1, idx};
         end
      end
   endfunction

   // State register. Reset returns the arbiter to IDLE with priority
   // starting at requester 0.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         beatCnt_q <= '0;
         rrPtr_q   <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         beatCnt_q <= beatCnt_d;
         rrPtr_q   <= rrPtr_d;
      end
   end

   // Next-state and output logic. A beat is accepted only from the owner
   // and only when the FIFO has room. On tenure end the pointer moves past
   // the old owner, so a requester that used up its burst is searched last.
   // Handover is decided in the same cycle, so the new owner is already
   // granted on the following cycle without an idle gap.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      beatCnt_d    = beatCnt_q;
      rrPtr_d      = rrPtr_q;
      accept       = 1'b0;
      tenureEnd    = 1'b0;
      pick         = '0;
      nextPtr      = '0;
      grant        = '0;
      fifo_wr_en   = 1'b0;
      fifo_data_in = '0;
      busy         = 1'b0;

      case (state_q)
         IDLE: begin
            pick = pickNext(req, rrPtr_q);
            if (pick[OW]) begin
               owner_d   = pick[OW-1:0];
               beatCnt_d = '0;
               state_d   = GRANT;
            end
         end
         GRANT: begin
            busy   = 1'b1;
            accept = req[owner_q] && !fifo_full;
            if (accept) begin
               grant[owner_q] = 1'b1;
               fifo_wr_en     = 1'b1;
               fifo_data_in   = req_data[owner_q*dataWidth +: dataWidth];
               beatCnt_d      = beatCnt_q + CW'(1);
            end
            tenureEnd = !req[owner_q] ||
                        (accept && ((int'(beatCnt_q) + 1 == maxBurst) ||
                                    fifo_almostFull));
            if (tenureEnd) begin
               nextPtr   = (owner_q == OW'(numReq - 1)) ? '0 : owner_q + 1'b1;
               rrPtr_d   = nextPtr;
               pick      = pickNext(req, nextPtr);
               beatCnt_d = '0;
               if (pick[OW]) begin
                  owner_d = pick[OW-1:0];
               end else begin
                  owner_d = '0;
                  state_d = IDLE;
               end
            end
         end
      endcase

      // Reset silences the FIFO side in the same cycle, so no beat is
      // written while the tenure is being aborted.
      if (rst_n) begin
         grant        = '0;
         fifo_wr_en   = 1'b0;
         fifo_data_in = '0;
         busy         = 1'b0;
      end
   end

   assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter with default parameters. Every
// cycle the outputs are compared against a tenure-level reference model.
// The model tracks who holds the write port, how many beats it has written,
// and where the next round-robin search starts. Directed sequences cover the
// round-robin rotation and a reset during a burst. These are followed by
// randomized traffic with sticky requests and random full and almostFull
// flags.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int MB = 4;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req;
   logic [N*DW-1:0]   req_data;
   logic              fifo_full;
   logic              fifo_almostFull;
   logic [N-1:0]      grant;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_data_in;
   logic [1:0]        owner;
   logic              busy;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   bit mBusy;
   int mOwner;
   int mCnt;
   int mPtr;

   fifo_wr_arbiter #(
      .dataWidth (DW),
      .numReq    (N),
      .maxBurst  (MB)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .req_data        (req_data),
      .fifo_full       (fifo_full),
      .fifo_almostFull (fifo_almostFull),
      .grant           (grant),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_data_in    (fifo_data_in),
      .owner           (owner),
      .busy            (busy)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                  tag, $time, observed, expected);
      end
   endtask

   // Round-robin search: first requester at or after ptr, wrapping
   function automatic int searchFrom(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // One cycle: drive inputs after the falling edge, compare outputs against
   // the model, then advance the model to what the next rising edge does.
   task automatic applyStimulus(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                                input logic full, input logic af,
                                input logic rst);
      bit            acc;
      bit            done;
      int            nxt;
      logic [N-1:0]  expGrant;
      logic [DW-1:0] expData;

      @(negedge clk);
      req             = r;
      req_data        = d;
      fifo_full       = full;
      fifo_almostFull = af;
      rst_n           = rst;
      #1;

      acc      = !rst && mBusy && r[mOwner] && !full;
      expGrant = acc ? N'(1 << mOwner) : '0;
      expData  = acc ? DW'(d >> (mOwner * DW)) : '0;
      checkOutput("grant",   32'(grant),        32'(expGrant));
      checkOutput("wrEn",    32'(fifo_wr_en),   32'(acc));
      checkOutput("dataIn",  32'(fifo_data_in), 32'(expData));
      checkOutput("busy",    32'(busy),         32'(!rst && mBusy));
      checkOutput("owner",   32'(owner),        32'(mOwner));

      if (rst) begin
         mBusy = 0; mOwner = 0; mCnt = 0; mPtr = 0;
      end else if (!mBusy) begin
         nxt = searchFrom(r, mPtr);
         if (nxt >= 0) begin
            mBusy = 1; mOwner = nxt; mCnt = 0;
         end
      end else begin
         if (acc) mCnt++;
         done = !r[mOwner] || (acc && (mCnt == MB || af));
         if (done) begin
            mPtr = (mOwner + 1) % N;
            nxt  = searchFrom(r, mPtr);
            mCnt = 0;
            if (nxt >= 0) begin
               mOwner = nxt;
            end else begin
               mBusy = 0; mOwner = 0;
            end
         end
      end
   endtask

   initial begin
      logic [N-1:0] rnd;
      int expOwner;

      req             = '0;
      req_data        = '0;
      fifo_full       = 1'b0;
      fifo_almostFull = 1'b0;
      rst_n           = 1'b1;
      mBusy = 0; mOwner = 0; mCnt = 0; mPtr = 0;

      for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);

      // All four requesting: the port rotates 0,1,2,3,0 with 4 beats each
      applyStimulus(4'b1111, $urandom, 1'b0, 1'b0, 1'b0);
      checkOutput("rrIdleFirst", 32'(busy), 32'd0);
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(4'b1111, $urandom, 1'b0, 1'b0, 1'b0);
         expOwner = ((n - 1) / MB) % N;
         checkOutput("rrOwner", 32'(owner), 32'(expOwner));
         checkOutput("rrGrant", 32'(grant), 32'(1 << expOwner));
      end

      // Reset in the middle of a burst, then restart from the lowest request
      applyStimulus(4'b1111, $urandom, 1'b0, 1'b0, 1'b1);
      checkOutput("rstWrEn", 32'(fifo_wr_en), 32'd0);
      applyStimulus(4'b0110, $urandom, 1'b0, 1'b0, 1'b0);
      checkOutput("rstIdle", 32'(busy), 32'd0);
      applyStimulus(4'b0110, $urandom, 1'b0, 1'b0, 1'b0);
      checkOutput("rstRegrant", 32'(grant), 32'b0010);

      // Randomized traffic: requests are sticky, so bursts run for a while
      rnd = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            if (rnd[b]) begin
               if ($urandom_range(7) == 0) rnd[b] = 1'b0;
            end else begin
               if ($urandom_range(3) == 0) rnd[b] = 1'b1;
            end
         end
         applyStimulus(rnd, $urandom,
                       ($urandom_range(6) == 0),
                       ($urandom_range(9) == 0),
                       ($urandom_range(60) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checkCount, errorCount);
      $finish;
   end

endmodule
